muldiv_unit: RTL

Iterative RV32M multiply/divide execution unit. It sits directly downstream of the register file read ports and upstream of its write port. It consumes the two source-register values, computes over multiple cycles, and returns the result, destination index and a one-cycle write strobe to the register-file write port. While it works, it raises busy so the single-cycle core holds its PC and suppresses its normal write.

---
 rtl/muldiv_if.sv | 35 +++
 rtl/muldiv_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_if
//  Purpose  : Request/response bundle between the core and muldiv_unit.
//             The core drives the request side: start, funct3, op_a, op_b
//             and rd_in. The unit returns busy, done, reg_write, rd_out
//             and result.
//  Modports : master - core side; slave - execution unit side.
//  Revision : 1.0 - initial release
// ============================================================================
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [4:0]      rd_in;
  logic            busy;
  logic            done;
  logic            reg_write;
  logic [4:0]      rd_out;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, op_a, op_b, rd_in,
    input  busy, done, reg_write, rd_out, result
  );

  modport slave (
    input  start, funct3, op_a, op_b, rd_in,
    output busy, done, reg_write, rd_out, result
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_unit
//  Purpose  : Iterative RV32M multiply/divide unit. Shift-add multiply and
//             restoring divide, one radix-2 step per clock, XLEN steps per
//             operation. Divide-by-zero and signed overflow finish in one
//             clock.
//  Ports    : clk   - core clock, rising edge
//             reset - asynchronous, active-low
//             bus   - muldiv_if.slave (start/funct3/op_a/op_b/rd_in in,
//                     busy/done/reg_write/rd_out/result out)
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic    clk,
  input  logic    reset,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] C_LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [4:0]        rd_q, rd_d;
  logic              neg_q, neg_d;          // product/quotient sign flip
  logic              rem_neg_q, rem_neg_d;  // remainder follows dividend
  logic [XLEN-1:0]   b_q, b_d;              // multiplicand / divisor magnitude
  logic [2*XLEN-1:0] acc_q, acc_d;          // {hi/remainder, multiplier/quotient}
  logic [XLEN-1:0]   result_q, result_d;

  // Operand conditioning at the request edge
  logic            w_a_signed, w_b_signed, w_sign_a, w_sign_b;
  logic [XLEN-1:0] w_mag_a, w_mag_b;
  logic            w_div_zero, w_div_ovf;

  assign w_a_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                      (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
  assign w_b_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                      (bus.funct3 == 3'b110);
  assign w_sign_a   = w_a_signed & bus.op_a[XLEN-1];
  assign w_sign_b   = w_b_signed & bus.op_b[XLEN-1];
  assign w_mag_a    = w_sign_a ? -bus.op_a : bus.op_a;
  assign w_mag_b    = w_sign_b ? -bus.op_b : bus.op_b;
  assign w_div_zero = bus.funct3[2] && (bus.op_b == '0);
  // Only the signed variants (DIV/REM) have funct3[0] clear
  assign w_div_ovf  = bus.funct3[2] && !bus.funct3[0] &&
                      (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op_b == '1);

  // Multiply step: add multiplicand into the high half when the current
  // multiplier LSB is set, then shift the whole accumulator right.
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next;
  assign w_mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign w_mul_next = {w_mul_sum, acc_q[XLEN-1:1]};

  // Restoring divide step: shift next dividend bit into the remainder and
  // keep the subtraction only when it does not go negative.
  logic [XLEN:0]     w_div_shift, w_div_diff;
  logic [2*XLEN-1:0] w_div_next;
  assign w_div_shift = acc_q[2*XLEN-1:XLEN-1];
  assign w_div_diff  = w_div_shift - {1'b0, b_q};
  assign w_div_next  = w_div_diff[XLEN]
                     ? {w_div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                     : {w_div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};

  // Final-iteration sign correction and result selection
  logic [2*XLEN-1:0] w_acc_next, w_prod_fix;
  logic [XLEN-1:0]   w_quo, w_rem, w_final;
  assign w_acc_next = funct3_q[2] ? w_div_next : w_mul_next;
  assign w_prod_fix = neg_q ? -w_acc_next : w_acc_next;
  assign w_quo      = neg_q ? -w_acc_next[XLEN-1:0] : w_acc_next[XLEN-1:0];
  assign w_rem      = rem_neg_q ? -w_acc_next[2*XLEN-1:XLEN] : w_acc_next[2*XLEN-1:XLEN];

  always_comb begin
    case (funct3_q)
      3'b000:                 w_final = w_prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_final = w_prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_final = w_quo;
      default:                w_final = w_rem;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    funct3_d  = funct3_q;
    rd_d      = rd_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    b_d       = b_q;
    acc_d     = acc_q;
    result_d  = result_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          funct3_d  = bus.funct3;
          rd_d      = bus.rd_in;
          neg_d     = w_sign_a ^ w_sign_b;
          rem_neg_d = w_sign_a;
          b_d       = w_mag_b;
          acc_d     = {{XLEN{1'b0}}, w_mag_a};
          cnt_d     = '0;
          if (w_div_zero) begin
            result_d = bus.funct3[1] ? bus.op_a : '1;
            state_d  = S_DONE;
          end else if (w_div_ovf) begin
            result_d = bus.funct3[1] ? '0 : bus.op_a;
            state_d  = S_DONE;
          end else begin
            state_d  = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + CW'(1);
        acc_d = w_acc_next;
        if (cnt_q == C_LAST) begin
          result_d = w_final;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      funct3_q  <= '0;
      rd_q      <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      b_q       <= '0;
      acc_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      funct3_q  <= funct3_d;
      rd_q      <= rd_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
    end
  end

  // Status decodes straight from state so an async reset clears them at once
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.reg_write = (state_q == S_DONE) && (rd_q != 5'd0);
  assign bus.rd_out    = rd_q;
  assign bus.result    = result_q;
endmodule
`default_nettype wire
